tank_dir_gen: RTL and testbench



---
 rtl/tank_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 51 +++++
 rtl/tank_dir_gen.sv | 93 +++++++++
 tb/tb_tank_dir_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared encodings between the tank direction producer and the tank/game logic.
// Holds direction codes, game-state codes, tank life and a lowest-set-bit helper.
package tank_pkg;

  localparam int unsigned DIR_W   = 3;
  localparam int unsigned GS_W    = 2;
  localparam int unsigned NUM_BTN = 4;

  localparam logic [DIR_W-1:0] DIR_UP    = 3'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd2;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd3;
  localparam logic [DIR_W-1:0] DIR_STAND = 3'd4;

  localparam logic [GS_W-1:0] GS_PLAY    = 2'b01;
  localparam logic [GS_W-1:0] GS_RESTART = 2'b10;

  localparam int unsigned TANK_LIFE = 3;

  typedef enum logic {
    CMD_IDLE  = 1'b0,
    CMD_ISSUE = 1'b1
  } cmd_state_e;

  // Index of the lowest set bit as a direction code; STAND when none is set.
  function automatic logic [DIR_W-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    logic [DIR_W-1:0] r;
    r = DIR_STAND;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) r = DIR_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: two-flop synchroniser, stability counter and
// debounced level, plus one-cycle pulses aligned with each level change.
// Ports: clk, rst (sync, active-high), raw (async button), held (debounced
// level), rise/fall (high in the first cycle held shows the new level).
module btn_debounce #(
  parameter int unsigned          CNT_W           = 20,
  parameter logic [CNT_W-1:0]     DEBOUNCE_CYCLES = CNT_W'(500000)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The counter's final step and the level toggle share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      held  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == held) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        held <= ~held;
        rise <= ~held;
        fall <= held;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tank_dir_gen.sv
// Per-player tank direction producer: debounces four direction buttons,
// tracks the most recently pressed one and issues one command per frame.
// Ports: clk, rst (sync, active-high), btn_raw[3:0] (UP,DOWN,LEFT,RIGHT),
// frame_tick, game_state[1:0]; direction_in[2:0], valid_take_direction
// (one-cycle strobe), btn_held[3:0] (debounced levels).
module tank_dir_gen
  import tank_pkg::*;
#(
  parameter int unsigned      CNT_W           = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(500000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               frame_tick,
  input  logic [GS_W-1:0]    game_state,
  output logic [DIR_W-1:0]   direction_in,
  output logic               valid_take_direction,
  output logic [NUM_BTN-1:0] btn_held
);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [DIR_W-1:0]   newest;
  logic [DIR_W-1:0]   newest_d;
  cmd_state_e         state;
  cmd_state_e         state_d;
  logic [DIR_W-1:0]   dir_d;

  // One conditioner per button.
  for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_btn
    btn_debounce #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .held (btn_held[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  // Newest press: a fresh press always wins; releasing the newest button
  // falls back to the lowest-index button still held.
  always_comb begin
    newest_d = newest;
    if (|rise) begin
      newest_d = lowest_set(rise);
    end else if (newest != DIR_STAND && fall[newest[1:0]]) begin
      newest_d = lowest_set(btn_held);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) newest <= DIR_STAND;
    else     newest <= newest_d;
  end

  // Command FSM next state; RESTART overrides everything.
  always_comb begin
    state_d = state;
    dir_d   = direction_in;
    case (state)
      CMD_IDLE: begin
        if (frame_tick && game_state == GS_PLAY) begin
          state_d = CMD_ISSUE;
          dir_d   = newest;
        end
      end
      CMD_ISSUE: state_d = CMD_IDLE;
      default:   state_d = CMD_IDLE;
    endcase
    if (game_state == GS_RESTART) begin
      state_d = CMD_IDLE;
      dir_d   = DIR_STAND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= CMD_IDLE;
      direction_in         <= DIR_STAND;
      valid_take_direction <= 1'b0;
    end else begin
      state                <= state_d;
      direction_in         <= dir_d;
      valid_take_direction <= (state_d == CMD_ISSUE);
    end
  end

endmodule

// File: tb/tb_tank_dir_gen.sv
module tb_tank_dir_gen;
  import tank_pkg::*;

  localparam int unsigned CNT_W = 20;
  localparam int unsigned SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       frame_tick;
  logic [1:0] game_state;
  logic [2:0] direction_in;
  logic       valid_take_direction;
  logic [3:0] btn_held;

  tank_dir_gen #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (20'd4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .btn_raw              (btn_raw),
    .frame_tick           (frame_tick),
    .game_state           (game_state),
    .direction_in         (direction_in),
    .valid_take_direction (valid_take_direction),
    .btn_held             (btn_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [2:0] dir;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] btn;
    logic [1:0] gs;
    bit         strobe;
    logic [3:0] held;
    logic [2:0] dir;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (valid_take_direction) begin
      exp_t e;
      chk("strobe_width", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe dir %0d expected none (cyc %0d)",
                 direction_in, cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_dir", 32'(direction_in), 32'(e.dir));
        chk("strobe_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
    prev_valid <= valid_take_direction;
  end

  initial begin
    vecs[0]  = '{4'b0001, GS_PLAY,    1'b1, 4'b0001, DIR_UP};
    vecs[1]  = '{4'b1001, GS_PLAY,    1'b1, 4'b1001, DIR_RIGHT};
    vecs[2]  = '{4'b0001, GS_PLAY,    1'b1, 4'b0001, DIR_UP};
    vecs[3]  = '{4'b0000, GS_PLAY,    1'b1, 4'b0000, DIR_STAND};
    vecs[4]  = '{4'b1100, GS_PLAY,    1'b1, 4'b1100, DIR_LEFT};
    vecs[5]  = '{4'b1000, GS_PLAY,    1'b1, 4'b1000, DIR_RIGHT};
    vecs[6]  = '{4'b0011, GS_PLAY,    1'b1, 4'b0011, DIR_UP};
    vecs[7]  = '{4'b0010, GS_PLAY,    1'b1, 4'b0010, DIR_DOWN};
    vecs[8]  = '{4'b0110, GS_PLAY,    1'b1, 4'b0110, DIR_LEFT};
    vecs[9]  = '{4'b0100, GS_PLAY,    1'b1, 4'b0100, DIR_LEFT};
    vecs[10] = '{4'b0001, GS_RESTART, 1'b0, 4'b0001, DIR_STAND};
    vecs[11] = '{4'b0001, GS_PLAY,    1'b1, 4'b0001, DIR_UP};
    vecs[12] = '{4'b0001, 2'b00,      1'b0, 4'b0001, DIR_UP};
    vecs[13] = '{4'b0001, 2'b11,      1'b0, 4'b0001, DIR_UP};

    rst        = 1'b1;
    btn_raw    = 4'b0000;
    frame_tick = 1'b0;
    game_state = GS_PLAY;
    cyc(2);
    chk("reset_dir", 32'(direction_in), 32'd4);
    chk("reset_valid", 32'(valid_take_direction), 32'd0);
    chk("reset_held", 32'(btn_held), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Short glitch must never reach btn_held.
    btn_raw = 4'b0001;
    cyc(3);
    btn_raw = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("glitch_held", 32'(btn_held), 32'd0);
    end

    // Stable press: btn_held rises exactly 6 edges after the raw change.
    btn_raw = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("press_latency", 32'(btn_held[0]), (k == 6) ? 32'd1 : 32'd0);
    end
    cyc(4);
    btn_raw = 4'b0000;
    cyc(10);
    chk("idle_dir", 32'(direction_in), 32'd4);

    // Table-driven button/game-state scenarios, each ending in a frame tick.
    for (int i = 0; i < 14; i++) begin
      btn_raw    = vecs[i].btn;
      game_state = vecs[i].gs;
      cyc(SETTLE);
      chk($sformatf("vec%0d_held", i), 32'(btn_held), 32'(vecs[i].held));
      frame_tick = 1'b1;
      if (vecs[i].strobe) exp_q.push_back('{vecs[i].dir, cyc_cnt + 1});
      cyc(1);
      frame_tick = 1'b0;
      cyc(3);
      chk($sformatf("vec%0d_dir", i), 32'(direction_in), 32'(vecs[i].dir));
    end

    // Back-to-back ticks yield a single strobe.
    game_state = GS_PLAY;
    cyc(1);
    frame_tick = 1'b1;
    exp_q.push_back('{DIR_UP, cyc_cnt + 1});
    cyc(2);
    frame_tick = 1'b0;
    cyc(4);
    chk("b2b_pending", 32'(exp_q.size()), 32'd0);

    // Reset while the strobe is high kills it on the next edge.
    frame_tick = 1'b1;
    exp_q.push_back('{DIR_UP, cyc_cnt + 1});
    cyc(1);
    frame_tick = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_valid", 32'(valid_take_direction), 32'd0);
    chk("rst_mid_dir", 32'(direction_in), 32'd4);
    chk("rst_mid_held", 32'(btn_held), 32'd0);
    rst = 1'b0;
    cyc(2);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc(1);
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
